// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
// Module   : seq_alu
// Summary  : Multi-cycle ALU. Most ops are single-cycle, while signed
//            multiply and divide iterate one bit per clock. The block uses a
//            start/busy/done handshake. Defining SEQ_ALU_OVERFLOW_EN adds a
//            signed-overflow flag output.
// Revision : 1.0  initial release
// ============================================================================
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               start,
  input  logic [4:0]         op_code,
  input  logic [WIDTH-1:0]   y,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic               div_zero,
  output logic [2*WIDTH-1:0] c
`ifdef SEQ_ALU_OVERFLOW_EN
  ,
  output logic               overflow
`endif
);

  localparam logic [4:0] c_op_add  = 5'b00011;
  localparam logic [4:0] c_op_sub  = 5'b00100;
  localparam logic [4:0] c_op_and  = 5'b00101;
  localparam logic [4:0] c_op_or   = 5'b00110;
  localparam logic [4:0] c_op_shr  = 5'b00111;
  localparam logic [4:0] c_op_shra = 5'b01000;
  localparam logic [4:0] c_op_shl  = 5'b01001;
  localparam logic [4:0] c_op_ror  = 5'b01010;
  localparam logic [4:0] c_op_rol  = 5'b01011;
  localparam logic [4:0] c_op_mul  = 5'b01111;
  localparam logic [4:0] c_op_div  = 5'b10000;
  localparam logic [4:0] c_op_neg  = 5'b10001;
  localparam logic [4:0] c_op_not  = 5'b10010;

  localparam int                 c_cnt_w    = $clog2(WIDTH + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_init = c_cnt_w'(WIDTH);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
  localparam logic [WIDTH-1:0]   c_width    = WIDTH'(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               r_state;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [2*WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]     r_opb;
  logic                 r_neg_q;
  logic                 r_neg_r;

  logic [WIDTH-1:0]     w_mag_y;
  logic [WIDTH-1:0]     w_mag_b;
  logic [WIDTH-1:0]     w_sum;
  logic [WIDTH-1:0]     w_diff;
  logic [WIDTH-1:0]     w_amt;
  logic [WIDTH-1:0]     w_lo;
  logic [2*WIDTH-1:0]   w_mul_sum;
  logic [2*WIDTH-1:0]   w_mul_res;
  logic [WIDTH-1:0]     w_rem_sh;
  logic [WIDTH:0]       w_trial;
  logic [WIDTH-1:0]     w_rem_nx;
  logic [WIDTH-1:0]     w_quo_nx;
  logic [WIDTH-1:0]     w_rem_res;
  logic [WIDTH-1:0]     w_quo_res;

  assign w_mag_y = y[WIDTH-1] ? -y : y;
  assign w_mag_b = b[WIDTH-1] ? -b : b;
  assign w_sum   = y + b;
  assign w_diff  = y - b;
  assign w_amt   = b % c_width;

  always_comb begin
    w_lo = '0;
    case (op_code)
      c_op_add:  w_lo = w_sum;
      c_op_sub:  w_lo = w_diff;
      c_op_and:  w_lo = y & b;
      c_op_or:   w_lo = y | b;
      c_op_shr:  w_lo = (b >= c_width) ? '0 : (y >> b);
      c_op_shra: w_lo = (b >= c_width) ? {WIDTH{y[WIDTH-1]}} : $unsigned($signed(y) >>> b);
      c_op_shl:  w_lo = (b >= c_width) ? '0 : (y << b);
      c_op_ror:  w_lo = (y >> w_amt) | (y << (c_width - w_amt));
      c_op_rol:  w_lo = (y << w_amt) | (y >> (c_width - w_amt));
      c_op_neg:  w_lo = -b;
      c_op_not:  w_lo = ~b;
      default:   w_lo = '0;
    endcase
  end

`ifdef SEQ_ALU_OVERFLOW_EN
  localparam logic [WIDTH-1:0] c_min_neg = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0] w_neg_b;
  logic             w_ovf;

  assign w_neg_b = -b;

  // Subtraction overflow is judged as y + (-b).
  always_comb begin
    w_ovf = 1'b0;
    case (op_code)
      c_op_add: w_ovf = (y[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != y[WIDTH-1]);
      c_op_sub: w_ovf = (y[WIDTH-1] == w_neg_b[WIDTH-1]) && (w_diff[WIDTH-1] != y[WIDTH-1]);
      c_op_neg: w_ovf = (b == c_min_neg);
      default:  w_ovf = 1'b0;
    endcase
  end
`endif

  // Shift-add multiply and restoring divide share r_acc; r_opb holds |b|.
  assign w_mul_sum = r_acc + (r_opb[0] ? r_mcand : '0);
  assign w_mul_res = r_neg_q ? -w_mul_sum : w_mul_sum;

  assign w_rem_sh  = r_acc[2*WIDTH-2:WIDTH-1];
  assign w_trial   = {1'b0, w_rem_sh} - {1'b0, r_opb};
  assign w_rem_nx  = w_trial[WIDTH] ? w_rem_sh : w_trial[WIDTH-1:0];
  assign w_quo_nx  = {r_acc[WIDTH-2:0], ~w_trial[WIDTH]};
  assign w_quo_res = r_neg_q ? -w_quo_nx : w_quo_nx;
  assign w_rem_res = r_neg_r ? -w_rem_nx : w_rem_nx;

  always_ff @(posedge clock) begin
    if (!clear) begin
      r_state  <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      c        <= '0;
`ifdef SEQ_ALU_OVERFLOW_EN
      overflow <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy     <= 1'b1;
            div_zero <= 1'b0;
`ifdef SEQ_ALU_OVERFLOW_EN
            overflow <= 1'b0;
`endif
            r_cnt    <= c_cnt_init;
            r_mcand  <= {{WIDTH{1'b0}}, w_mag_y};
            r_opb    <= w_mag_b;
            r_neg_q  <= y[WIDTH-1] ^ b[WIDTH-1];
            r_neg_r  <= y[WIDTH-1];
            if (op_code == c_op_mul) begin
              r_acc   <= '0;
              r_state <= S_MUL;
            end else if (op_code == c_op_div && b != '0) begin
              r_acc   <= {{WIDTH{1'b0}}, w_mag_y};
              r_state <= S_DIV;
            end else if (op_code == c_op_div) begin
              c        <= {y, {WIDTH{1'b1}}};
              div_zero <= 1'b1;
              done     <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              c       <= {{WIDTH{1'b0}}, w_lo};
`ifdef SEQ_ALU_OVERFLOW_EN
              overflow <= w_ovf;
`endif
              done    <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_MUL: begin
          r_acc   <= w_mul_sum;
          r_mcand <= r_mcand << 1;
          r_opb   <= r_opb >> 1;
          r_cnt   <= r_cnt - c_cnt_one;
          if (r_cnt == c_cnt_one) begin
            c       <= w_mul_res;
            done    <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DIV: begin
          r_acc <= {w_rem_nx, w_quo_nx};
          r_cnt <= r_cnt - c_cnt_one;
          if (r_cnt == c_cnt_one) begin
            c       <= {w_rem_res, w_quo_res};
            done    <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// Testbench for seq_alu (WIDTH=32): directed cases plus randomized ops
// compared against a longint-arithmetic reference model.
module tb_seq_alu;
  localparam int WIDTH = 32;

  localparam logic [4:0] c_op_add  = 5'b00011;
  localparam logic [4:0] c_op_sub  = 5'b00100;
  localparam logic [4:0] c_op_shr  = 5'b00111;
  localparam logic [4:0] c_op_shra = 5'b01000;
  localparam logic [4:0] c_op_shl  = 5'b01001;
  localparam logic [4:0] c_op_ror  = 5'b01010;
  localparam logic [4:0] c_op_rol  = 5'b01011;
  localparam logic [4:0] c_op_mul  = 5'b01111;
  localparam logic [4:0] c_op_div  = 5'b10000;
  localparam logic [4:0] c_op_neg  = 5'b10001;
  localparam logic [4:0] c_op_and  = 5'b00101;
  localparam logic [4:0] c_op_or   = 5'b00110;
  localparam logic [4:0] c_op_not  = 5'b10010;

  localparam longint c_smax = 64'sd2147483647;
  localparam longint c_smin = -64'sd2147483648;

  logic        clock = 1'b0;
  logic        clear;
  logic        start;
  logic [4:0]  op_code;
  logic [31:0] y;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [63:0] c;
`ifdef SEQ_ALU_OVERFLOW_EN
  logic        overflow;
`endif

  int total = 0;
  int bad   = 0;

  seq_alu #(.WIDTH(WIDTH)) dut (
    .clock    (clock),
    .clear    (clear),
    .start    (start),
    .op_code  (op_code),
    .y        (y),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .c        (c)
`ifdef SEQ_ALU_OVERFLOW_EN
    ,
    .overflow (overflow)
`endif
  );

  always #5 clock = ~clock;

  // Reference model: signed 64-bit arithmetic on the operation's definition.
  function automatic void model(input logic [4:0] op, input logic [31:0] ya, input logic [31:0] yb,
                                output logic [63:0] ec, output logic edz, output logic eovf);
    longint sa, sb, r, p, q, rm, u;
    logic [31:0] v, nb;
    int n;
    sa = longint'($signed(ya));
    sb = longint'($signed(yb));
    u  = longint'({32'd0, ya});
    ec = 64'd0; edz = 1'b0; eovf = 1'b0;
    case (op)
      c_op_add: begin
        r = sa + sb; ec = {32'd0, r[31:0]}; eovf = (r > c_smax) || (r < c_smin);
      end
      c_op_sub: begin
        nb = -yb; r = sa + longint'($signed(nb)); eovf = (r > c_smax) || (r < c_smin);
        v = ya - yb; ec = {32'd0, v};
      end
      c_op_and: ec = {32'd0, ya & yb};
      c_op_or:  ec = {32'd0, ya | yb};
      c_op_shr: begin
        if (yb >= 32) r = 0; else begin p = 64'sd1 <<< yb; r = u / p; end
        ec = {32'd0, r[31:0]};
      end
      c_op_shra: begin
        if (yb >= 32) r = (sa < 0) ? -1 : 0;
        else begin
          p = 64'sd1 <<< yb; r = sa / p;
          if (sa < 0 && r * p != sa) r = r - 1;
        end
        ec = {32'd0, r[31:0]};
      end
      c_op_shl: begin
        if (yb >= 32) r = 0; else begin p = 64'sd1 <<< yb; r = u * p; end
        ec = {32'd0, r[31:0]};
      end
      c_op_ror: begin
        n = int'(yb % 32); v = ya;
        repeat (n) v = {v[0], v[31:1]};
        ec = {32'd0, v};
      end
      c_op_rol: begin
        n = int'(yb % 32); v = ya;
        repeat (n) v = {v[30:0], v[31]};
        ec = {32'd0, v};
      end
      c_op_mul: begin
        r = sa * sb; ec = r;
      end
      c_op_div: begin
        if (yb == 32'd0) begin
          ec = {ya, 32'hFFFFFFFF}; edz = 1'b1;
        end else begin
          q = sa / sb; rm = sa % sb; ec = {rm[31:0], q[31:0]};
        end
      end
      c_op_neg: begin
        v = -yb; ec = {32'd0, v}; eovf = (yb == 32'h80000000);
      end
      c_op_not: ec = {32'd0, ~yb};
      default:  ec = 64'd0;
    endcase
  endfunction

  // Issues one op once idle, scrambles inputs after the accept edge, and
  // returns the accept-to-done latency in cycles (-1 if done never came).
  task automatic do_op(input logic [4:0] op, input logic [31:0] ya, input logic [31:0] yb,
                       output int lat);
    for (int k = 0; k < 100 && busy; k++) begin @(posedge clock); #1; end
    op_code = op; y = ya; b = yb; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; op_code = 5'($urandom); y = $urandom; b = $urandom;
    lat = 1;
    while (!done && lat < 100) begin @(posedge clock); #1; lat++; end
    if (!done) lat = -1;
  endtask

  task automatic test_reset();
    int lat;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    total++; if (div_zero !== 1'b0) begin bad++; $display("FAIL reset_dz: got %b want 0", div_zero); end
    total++; if (c !== 64'd0) begin bad++; $display("FAIL reset_c: got %h want 0", c); end
    clear = 1'b1;
    do_op(c_op_add, 32'd1, 32'd2, lat);
    @(posedge clock); #1;
    op_code = c_op_mul; y = 32'hFFFFFFFD; b = 32'd7; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clock); #1; end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_mul_busy: got %b want 1", busy); end
    clear = 1'b0;
    @(posedge clock); #1;
    clear = 1'b1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL abort_done: got %b want 0", done); end
    total++; if (c !== 64'd0) begin bad++; $display("FAIL abort_c: got %h want 0", c); end
    do_op(c_op_add, 32'd5, 32'd7, lat);
    total++; if (lat !== 1) begin bad++; $display("FAIL add_lat: got %0d want 1", lat); end
    total++; if (c !== 64'h0000_0000_0000_000C) begin bad++; $display("FAIL add_c: got %h want c", c); end
  endtask

  task automatic test_mul();
    int lat;
    bit held;
    logic [63:0] ec;
    logic edz, eovf;
    logic [31:0] ya, yb;
    do_op(c_op_add, 32'h1234, 32'd1, lat);
    for (int k = 0; k < 100 && busy; k++) begin @(posedge clock); #1; end
    op_code = c_op_mul; y = 32'hFFFFFFFD; b = 32'd7; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; op_code = c_op_add; y = $urandom; b = $urandom;
    lat = 1; held = 1'b1;
    while (!done && lat < 100) begin
      if (c !== 64'h1235) held = 1'b0;
      @(posedge clock); #1; lat++;
    end
    total++; if (lat !== 33) begin bad++; $display("FAIL mul_lat: got %0d want 33", lat); end
    total++; if (held !== 1'b1) begin bad++; $display("FAIL mul_c_held: got %b want 1", held); end
    total++; if (c !== 64'hFFFFFFFF_FFFFFFEB) begin bad++; $display("FAIL mul_neg3x7: got %h want ffffffffffffffeb", c); end
    do_op(c_op_mul, 32'h7FFFFFFF, 32'h7FFFFFFF, lat);
    total++; if (c !== 64'h3FFFFFFF_00000001) begin bad++; $display("FAIL mul_max: got %h want 3fffffff00000001", c); end
    for (int i = 0; i < 8; i++) begin
      ya = (i == 0) ? 32'h80000000 : $urandom;
      yb = (i == 1) ? 32'h80000000 : $urandom;
      model(c_op_mul, ya, yb, ec, edz, eovf);
      do_op(c_op_mul, ya, yb, lat);
      total++; if (lat !== 33) begin bad++; $display("FAIL mul_rand_lat: got %0d want 33", lat); end
      total++; if (c !== ec) begin bad++; $display("FAIL mul_rand %h*%h: got %h want %h", ya, yb, c, ec); end
    end
  endtask

  task automatic test_div();
    int lat;
    logic [63:0] ec;
    logic edz, eovf;
    logic [31:0] ya, yb;
    do_op(c_op_div, 32'hFFFFFFEF, 32'd5, lat);
    total++; if (lat !== 33) begin bad++; $display("FAIL div_lat: got %0d want 33", lat); end
    total++; if (c !== 64'hFFFFFFFE_FFFFFFFD) begin bad++; $display("FAIL div_m17_5: got %h want fffffffefffffffd", c); end
    do_op(c_op_div, 32'h80000000, 32'hFFFFFFFF, lat);
    total++; if (c !== 64'h00000000_80000000) begin bad++; $display("FAIL div_minneg: got %h want 0000000080000000", c); end
    for (int i = 0; i < 8; i++) begin
      ya = $urandom;
      yb = (i < 4) ? $urandom_range(0, 300) : $urandom;
      if (i == 2) yb = 32'hFFFFFFF9;
      model(c_op_div, ya, yb, ec, edz, eovf);
      do_op(c_op_div, ya, yb, lat);
      total++; if (lat !== (edz ? 1 : 33)) begin bad++; $display("FAIL div_rand_lat: got %0d", lat); end
      total++; if (c !== ec) begin bad++; $display("FAIL div_rand %h/%h: got %h want %h", ya, yb, c, ec); end
      total++; if (div_zero !== edz) begin bad++; $display("FAIL div_rand_dz: got %b want %b", div_zero, edz); end
    end
  endtask

  task automatic test_div_zero();
    int lat;
    do_op(c_op_div, 32'd100, 32'd0, lat);
    total++; if (lat !== 1) begin bad++; $display("FAIL dz_lat: got %0d want 1", lat); end
    total++; if (div_zero !== 1'b1) begin bad++; $display("FAIL dz_flag: got %b want 1", div_zero); end
    total++; if (c !== 64'h00000064_FFFFFFFF) begin bad++; $display("FAIL dz_c: got %h want 00000064ffffffff", c); end
    do_op(c_op_div, 32'd20, 32'd3, lat);
    total++; if (div_zero !== 1'b0) begin bad++; $display("FAIL dz_clear: got %b want 0", div_zero); end
    total++; if (c !== 64'h00000002_00000006) begin bad++; $display("FAIL div_20_3: got %h want 0000000200000006", c); end
  endtask

  task automatic test_single_ops();
    int lat;
    logic [63:0] ec;
    logic edz, eovf;
    logic [31:0] ya, yb;
    logic [4:0] op;
    do_op(c_op_ror, 32'h80000001, 32'd1, lat);
    total++; if (c !== 64'hC0000000) begin bad++; $display("FAIL ror1: got %h want c0000000", c); end
    do_op(c_op_rol, 32'h80000001, 32'd33, lat);
    total++; if (c !== 64'h00000003) begin bad++; $display("FAIL rol33: got %h want 3", c); end
    do_op(c_op_shra, 32'h80000001, 32'd40, lat);
    total++; if (c !== 64'hFFFFFFFF) begin bad++; $display("FAIL shra40: got %h want ffffffff", c); end
    do_op(c_op_shr, 32'h80000001, 32'd32, lat);
    total++; if (c !== 64'd0) begin bad++; $display("FAIL shr32: got %h want 0", c); end
    for (int i = 0; i < 48; i++) begin
      op = 5'($urandom_range(0, 31));
      if (op == c_op_mul || op == c_op_div) op = c_op_sub;
      ya = $urandom;
      yb = $urandom_range(0, 1) ? $urandom_range(0, 40) : $urandom;
      model(op, ya, yb, ec, edz, eovf);
      do_op(op, ya, yb, lat);
      total++; if (lat !== 1) begin bad++; $display("FAIL op%0d_lat: got %0d want 1", op, lat); end
      total++; if (c !== ec) begin bad++; $display("FAIL op%0d %h,%h: got %h want %h", op, ya, yb, c, ec); end
`ifdef SEQ_ALU_OVERFLOW_EN
      total++; if (overflow !== eovf) begin bad++; $display("FAIL op%0d_ovf: got %b want %b", op, overflow, eovf); end
`endif
    end
  endtask

  task automatic test_back_to_back();
    int dones;
    for (int k = 0; k < 100 && busy; k++) begin @(posedge clock); #1; end
    op_code = c_op_div; y = 32'hFFFFFFEF; b = 32'd5; start = 1'b1;
    @(posedge clock); #1;
    op_code = c_op_add; y = 32'd5; b = 32'd7;
    dones = 0;
    for (int i = 1; i <= 33; i++) begin
      if (done === 1'b1) dones++;
      if (i != 33) begin @(posedge clock); #1; end
    end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL b2b_done33: got %b want 1", done); end
    total++; if (dones !== 1) begin bad++; $display("FAIL b2b_done_count: got %0d want 1", dones); end
    total++; if (c !== 64'hFFFFFFFE_FFFFFFFD) begin bad++; $display("FAIL b2b_div_c: got %h want fffffffefffffffd", c); end
    @(posedge clock); #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_idle_busy: got %b want 0", busy); end
    total++; if (c !== 64'hFFFFFFFE_FFFFFFFD) begin bad++; $display("FAIL b2b_c_hold: got %h want fffffffefffffffd", c); end
    @(posedge clock); #1;
    start = 1'b0;
    total++; if (busy !== 1'b1 || done !== 1'b1) begin bad++; $display("FAIL b2b_next_accept: got busy=%b done=%b want 1 1", busy, done); end
    total++; if (c !== 64'h0000_0000_0000_000C) begin bad++; $display("FAIL b2b_add_c: got %h want c", c); end
  endtask

`ifdef SEQ_ALU_OVERFLOW_EN
  task automatic test_overflow();
    int lat;
    do_op(c_op_add, 32'h7FFFFFFF, 32'd1, lat);
    total++; if (c !== 64'h80000000) begin bad++; $display("FAIL ovf_add_c: got %h want 80000000", c); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_add: got %b want 1", overflow); end
    do_op(c_op_sub, 32'd5, 32'd3, lat);
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_sub: got %b want 0", overflow); end
    total++; if (c !== 64'd2) begin bad++; $display("FAIL ovf_sub_c: got %h want 2", c); end
    do_op(c_op_neg, 32'd0, 32'h80000000, lat);
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_neg: got %b want 1", overflow); end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    clear = 1'b0; start = 1'b0; op_code = 5'd0; y = 32'd0; b = 32'd0;
    repeat (3) @(posedge clock);
    #1;
    test_reset();
    test_mul();
    test_div();
    test_div_zero();
    test_single_ops();
    test_back_to_back();
`ifdef SEQ_ALU_OVERFLOW_EN
    test_overflow();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, multi-cycle successor to the datapath ALU. Same 5-bit op-code map.
- Multiply and divide become iterative: one bit per clock. All other ops complete in one registered cycle.
- Uses a start/busy/done handshake so the control unit can stall while a multiply or divide is in progress.
- Drives a registered 2*WIDTH result bus into the HI/LO and Z registers.

Parameters:
- WIDTH, 32, operand width in bits; must be even and >= 8.

Ports:
- clock  in  1  system clock, rising edge
- clear  in  1  synchronous reset, active-low; sampled on the rising edge of clock
- start  in  1  request; accepted only when busy=0
- op_code  in  5  operation select, latched when start is accepted
- y  in  WIDTH  operand A (dividend / multiplicand / shift source)
- b  in  WIDTH  operand B (divisor / multiplier / shift amount)
- busy  out  1  high from the accept edge until done falls
- done  out  1  one-cycle pulse; result valid from this cycle on
- div_zero  out  1  set with done when a divide had b=0
- c  out  2*WIDTH  result {hi, lo}; held until the next accepted op

Behaviour:
- Reset (clear=0 at an edge): state=IDLE; c=0, busy=0, done=0, div_zero=0. Applies even mid-operation: any in-flight op is discarded.
- States:
  - IDLE: start=1 latches y, b and op_code.
    - mul (01111) → MUL; div (10000) with b≠0 → DIV.
    - Any other op → DONE, with c written on the same edge.
  - MUL / DIV: iterate WIDTH edges, counting down; on the last iteration, write c and → DONE.
  - DONE: done=1 for exactly one cycle, then → IDLE.
- busy = (state ≠ IDLE). start while busy=1 is ignored; it is not queued.
- Latency, from the accept edge to the done cycle:
  - single-cycle ops: 1 cycle
  - mul/div: WIDTH+1 cycles
  - Throughput: one op per 2 cycles (single-cycle ops) or WIDTH+2 cycles (mul/div).
- Single-cycle ops: result goes to lo, and hi=0.
  - add 00011, sub 00100: modulo 2^WIDTH.
  - and 00101, or 00110.
  - shr 00111: logical right shift.
  - shra 01000: arithmetic right shift.
  - shl 01001: left shift.
  - ror 01010, rol 01011: rotate; amount = b mod WIDTH.
  - neg 10001: two's complement of b.
  - not 10010: bitwise NOT of b.
  - Any other op: c=0.
- Shift amounts are the full value of b:
  - shr or shl with b >= WIDTH gives 0.
  - shra with b >= WIDTH gives all copies of y's sign bit.
- mul: signed × signed.
  - Shift-add on operand magnitudes, then negate the 2*WIDTH product if the operand signs differ.
  - Full product goes to {hi, lo}.
- div: signed restoring division on magnitudes.
  - lo = quotient, truncated toward zero; hi = remainder, carrying the dividend's sign.
  - Most-negative ÷ -1: lo = most-negative, hi = 0 (wraps, no flag).
- Divide by zero: no iteration. IDLE → DONE with lo = all ones, hi = y, div_zero=1.
- div_zero is cleared on the next accepted op.
- Operand or op_code changes after the accept edge have no effect on the in-flight op.

Optional Feature:
- Macro: SEQ_ALU_OVERFLOW_EN.
- Defined:
  - Adds output port overflow (1 bit, reset 0).
  - Set with done when add or sub overflows in signed arithmetic: operand signs equal and result sign differs (for sub, compare y with -b).
  - Set when neg is applied to the most-negative value.
  - Cleared on the next accepted op.
- Undefined: the port is absent, and no overflow logic is built.

Test Plan:
- Reset: clear=0 during a mul at its 10th iteration → next cycle busy=0, done=0, c=0. A new add 5+7 then gives c=0x0000000C, 0x00000000... concretely {hi=0, lo=12}, done one cycle after accept.
- mul (WIDTH=32): y=-3 (0xFFFFFFFD), b=7 → done exactly 33 cycles after accept; c=0xFFFFFFFF_FFFFFFEB. Also 0x7FFFFFFF × 0x7FFFFFFF → 0x3FFFFFFF_00000001.
- div: y=-17, b=5 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFE (-2). div y=100, b=0 → done one cycle after accept, div_zero=1, lo=0xFFFFFFFF, hi=100.
- Shifts/rotates: y=0x80000001.
  - ror b=1 → 0xC0000000.
  - rol b=33 → 0x00000003.
  - shra b=40 → 0xFFFFFFFF.
  - shr b=32 → 0.
- Handshake: start held high every cycle during a div → exactly one op executes. The next op is accepted the cycle after done falls. c holds its value between ops.
- With SEQ_ALU_OVERFLOW_EN: add 0x7FFFFFFF+1 → lo=0x80000000, overflow=1. sub 5-3 → overflow=0.
